// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types and constants for pixel_packetizer
package pkt_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PIX, CSUM} tx_state_t;
  typedef enum logic [1:0] {FREE, FILL, COMMITTED, SENDING} bank_t;
  localparam int HDR_BYTES = 4;
endpackage

// File: rtl/pkt_bank_ram.sv
// pkt_bank_ram: simple dual-port 24-bit pixel RAM, synchronous read; address MSB selects the bank
module pkt_bank_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [23:0]   wdata,
  output logic [23:0]   rdata
);
  logic [23:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pixel_packetizer.sv
// pixel_packetizer: packs ena-qualified pixels into two-bank segments and streams them as byte packets.
// Define PKT_CSUM_EN to append an XOR checksum byte to every packet.
module pixel_packetizer
  import pkt_pkg::*;
#(
  parameter int SEG_PIXELS = 160,
  parameter int DROP_W     = 16
) (
  input  logic              pclk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [23:0]       bramaddr24b,
  input  logic [7:0]        rgb_r,
  input  logic [7:0]        rgb_g,
  input  logic [7:0]        rgb_b,
  input  logic              start_frame,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic [DROP_W-1:0] drop_count,
  output logic [7:0]        frame_no
);
  localparam int PW = SEG_PIXELS > 1 ? $clog2(SEG_PIXELS) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(SEG_PIXELS - 1);
  tx_state_t state, state_n;
  bank_t st [2];
  bank_t st_n [2];
  logic [23:0] hdr_addr [2];
  logic [7:0] hdr_frame [2];
  logic [PW-1:0] wr_ptr, wr_ptr_n, ptr, rd_ptr, rd_ptr_n;
  logic [1:0] hdr_idx, hdr_idx_n, phase, phase_n;
  logic rd_bank, rd_bank_n, out_bank, out_bank_n, wbank, filling, we, hdr_we, drop_inc;
  logic take, done, load, tx_valid_n, tx_last_n;
  logic [7:0] tx_data_n, hdr_byte, pix_byte, frame_in;
  logic [23:0] rdata;
`ifdef PKT_CSUM_EN
  logic [7:0] csum;
`endif
  // A segment claims a free bank only at its first pixel; with no bank to claim it is discarded and counted.
  always_comb begin
    st_n = st;
    if (tx_valid && tx_ready && tx_last) st_n[out_bank] = FREE;
    if (take) st_n[rd_bank_n] = SENDING;
    for (int b = 0; b < 2; b++) if (start_frame && st[b] == FILL) st_n[b] = FREE;
    ptr = start_frame ? '0 : wr_ptr;
    filling = st_n[0] == FILL || st_n[1] == FILL;
    wbank = st_n[1] == FILL;
    if (ena && ptr == '0 && !filling && (st_n[0] == FREE || st_n[1] == FREE)) begin
      wbank = st_n[0] != FREE;
      st_n[wbank] = FILL;
      filling = 1'b1;
    end
    we = ena && filling;
    hdr_we = we && ptr == '0;
    drop_inc = ena && ptr == LAST_PIX && !filling;
    if (we && ptr == LAST_PIX) st_n[wbank] = COMMITTED;
    wr_ptr_n = !ena ? ptr : ptr == LAST_PIX ? '0 : ptr + 1'b1;
    frame_in = start_frame ? frame_no + 8'd1 : frame_no;
  end
  // RAM is addressed with next-cycle pointers so rdata always holds the pixel at rd_ptr.
  always_comb begin
    state_n = state;
    rd_ptr_n = rd_ptr;
    rd_bank_n = rd_bank;
    hdr_idx_n = hdr_idx;
    phase_n = phase;
    out_bank_n = out_bank;
    tx_valid_n = tx_valid && !tx_ready;
    tx_data_n = tx_data;
    tx_last_n = tx_last;
    take = 1'b0;
    done = 1'b0;
    load = !tx_valid || tx_ready;
    hdr_byte = hdr_idx == 2'd0 ? hdr_frame[rd_bank] : hdr_idx == 2'd1 ? hdr_addr[rd_bank][23:16] :
               hdr_idx == 2'd2 ? hdr_addr[rd_bank][15:8] : hdr_addr[rd_bank][7:0];
    pix_byte = phase == 2'd0 ? rdata[23:16] : phase == 2'd1 ? rdata[15:8] : rdata[7:0];
    if (state == IDLE) begin
      take = st[0] == COMMITTED || st[1] == COMMITTED;
      rd_bank_n = take ? st[0] != COMMITTED : rd_bank;
      state_n = take ? HDR : IDLE;
    end else if (load) begin
      tx_valid_n = 1'b1;
      tx_last_n = 1'b0;
      out_bank_n = rd_bank;
      if (state == HDR) begin
        tx_data_n = hdr_byte;
        hdr_idx_n = hdr_idx + 2'd1;
        state_n = hdr_idx == 2'(HDR_BYTES - 1) ? PIX : HDR;
      end else if (state == PIX) begin
        tx_data_n = pix_byte;
        phase_n = phase == 2'd2 ? 2'd0 : phase + 2'd1;
        rd_ptr_n = phase == 2'd2 ? rd_ptr + 1'b1 : rd_ptr;
`ifdef PKT_CSUM_EN
        state_n = phase == 2'd2 && rd_ptr == LAST_PIX ? CSUM : PIX;
      end else begin
        tx_data_n = csum;
        tx_last_n = 1'b1;
        done = 1'b1;
      end
`else
        done = phase == 2'd2 && rd_ptr == LAST_PIX;
        tx_last_n = done;
      end
`endif
      if (done) begin
        take = st[!rd_bank] == COMMITTED;
        rd_bank_n = take ? !rd_bank : rd_bank;
        state_n = take ? HDR : IDLE;
      end
    end
    if (take) begin
      rd_ptr_n = '0;
      hdr_idx_n = '0;
      phase_n = '0;
    end
  end
  always_ff @(posedge pclk or negedge rstb)
    if (!rstb) begin
      st <= '{FREE, FREE};
      wr_ptr <= '0;
      frame_no <= '0;
      drop_count <= '0;
      state <= IDLE;
      rd_ptr <= '0;
      rd_bank <= 1'b0;
      out_bank <= 1'b0;
      hdr_idx <= '0;
      phase <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      tx_last <= 1'b0;
    end else begin
      st <= st_n;
      wr_ptr <= wr_ptr_n;
      if (start_frame) frame_no <= frame_no + 8'd1;
      if (drop_inc && drop_count != '1) drop_count <= drop_count + 1'b1;
      state <= state_n;
      rd_ptr <= rd_ptr_n;
      rd_bank <= rd_bank_n;
      out_bank <= out_bank_n;
      hdr_idx <= hdr_idx_n;
      phase <= phase_n;
      tx_valid <= tx_valid_n;
      tx_data <= tx_data_n;
      tx_last <= tx_last_n;
    end
  always_ff @(posedge pclk)
    if (hdr_we) begin
      hdr_addr[wbank] <= bramaddr24b;
      hdr_frame[wbank] <= frame_in;
    end
`ifdef PKT_CSUM_EN
  always_ff @(posedge pclk or negedge rstb)
    if (!rstb) csum <= '0;
    else if (load && (state == HDR || state == PIX))
      csum <= (state == HDR && hdr_idx == 2'd0) ? tx_data_n : csum ^ tx_data_n;
`endif
  pkt_bank_ram #(.AW(PW + 1)) ram (
    .clk(pclk),
    .we(we),
    .waddr({wbank, ptr}),
    .raddr({rd_bank_n, rd_ptr_n}),
    .wdata({rgb_r, rgb_g, rgb_b}),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_pixel_packetizer.sv
// tb_pixel_packetizer: table-driven single-segment packet checks plus drop, reset and frame-wrap sequences
module tb_pixel_packetizer;
  localparam int SEG = 160;
`ifdef PKT_CSUM_EN
  localparam int PLEN = 5 + 3 * SEG;
`else
  localparam int PLEN = 4 + 3 * SEG;
`endif
  typedef struct {
    logic [23:0] base;
    int          n_sf;
    int          pre;
    bit          bp;
    logic [7:0]  exp_frame;
    int          exp_drop;
  } vec_t;
  logic pclk = 1'b0, rstb = 1'b0, ena = 1'b0, start_frame = 1'b0, tx_ready = 1'b0;
  logic [23:0] bramaddr24b = '0;
  logic [7:0] rgb_r = '0, rgb_g = '0, rgb_b = '0;
  logic tx_valid, tx_last;
  logic [7:0] tx_data, frame_no;
  logic [15:0] drop_count;
  int checks = 0, errors = 0, cyc = 0, n_last = 0;
  bit bp_mode = 1'b0;
  logic [7:0] got_d[$];
  logic [7:0] exp_q[$];
  bit got_l[$];
  int got_c[$];
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;
  logic v1, v2, v3;
  vec_t tbl[5];

  pixel_packetizer #(.SEG_PIXELS(SEG), .DROP_W(16)) dut (
    .pclk(pclk), .rstb(rstb), .ena(ena), .bramaddr24b(bramaddr24b),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .start_frame(start_frame),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .drop_count(drop_count), .frame_no(frame_no)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge pclk);
    cyc++;
    if (rstb) begin
      if (pv && !pr) check("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, pl, pd});
      if (tx_valid && tx_ready) begin
        got_d.push_back(tx_data);
        got_l.push_back(tx_last);
        got_c.push_back(cyc);
        if (tx_last) n_last++;
      end
    end
    pv = rstb && tx_valid;
    pr = tx_ready;
    pd = tx_data;
    pl = tx_last;
  end

  initial forever begin
    @(posedge pclk);
    #1;
    if (bp_mode) tx_ready = 1'($urandom_range(0, 1));
  end

  task automatic pix(input logic [23:0] a);
    @(posedge pclk);
    #1;
    ena = 1'b1;
    bramaddr24b = a;
    rgb_r = a[7:0];
    rgb_g = ~a[7:0];
    rgb_b = 8'h5A;
  endtask

  task automatic sf();
    @(posedge pclk);
    #1;
    ena = 1'b0;
    start_frame = 1'b1;
    @(posedge pclk);
    #1;
    start_frame = 1'b0;
  endtask

  task automatic do_reset();
    bp_mode = 1'b0;
    rstb = 1'b0;
    ena = 1'b0;
    start_frame = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge pclk);
    #1 rstb = 1'b1;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    exp_q.delete();
    n_last = 0;
  endtask

  task automatic add_pkt(input logic [7:0] f, input logic [23:0] base);
    logic [23:0] a;
    exp_q.push_back(f);
    exp_q.push_back(base[23:16]);
    exp_q.push_back(base[15:8]);
    exp_q.push_back(base[7:0]);
    for (int i = 0; i < SEG; i++) begin
      a = base + 24'(i);
      exp_q.push_back(a[7:0]);
      exp_q.push_back(~a[7:0]);
      exp_q.push_back(8'h5A);
    end
`ifdef PKT_CSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      for (int i = exp_q.size() - (PLEN - 1); i < exp_q.size(); i++) x ^= exp_q[i];
      exp_q.push_back(x);
    end
`endif
  endtask

  task automatic wait_pkts(input int n, input string tag);
    int t;
    t = 0;
    while (n_last < n && t < 20000) begin
      @(negedge pclk);
      t++;
    end
    check({tag, "_timeout"}, 64'(t < 20000), 64'd1);
    repeat (20) @(negedge pclk);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, 64'(got_d.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), got_d[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(((i + 1) % PLEN) == 0));
    end
  endtask

  initial begin
    tbl[0] = '{24'h000000, 1, 0,   1'b0, 8'h01, 0};
    tbl[1] = '{24'h000000, 1, 0,   1'b1, 8'h01, 0};
    tbl[2] = '{24'h123456, 3, 0,   1'b0, 8'h03, 0};
    tbl[3] = '{24'h000000, 1, 100, 1'b0, 8'h02, 0};
    tbl[4] = '{24'hFFFF60, 2, 0,   1'b1, 8'h02, 0};

    for (int c = 0; c < 20; c++) begin
      @(posedge pclk);
      #1;
      ena = 1'($urandom_range(0, 1));
      start_frame = 1'($urandom_range(0, 1));
      tx_ready = 1'($urandom_range(0, 1));
      bramaddr24b = 24'($urandom);
      rgb_r = 8'($urandom);
      @(negedge pclk);
      check("reset_outputs", {tx_valid, tx_last, tx_data, frame_no, drop_count}, 64'd0);
    end

    foreach (tbl[k]) begin
      do_reset();
      bp_mode = tbl[k].bp;
      tx_ready = !tbl[k].bp;
      repeat (tbl[k].n_sf) sf();
      for (int i = 0; i < tbl[k].pre; i++) pix(tbl[k].base + 24'(i));
      if (tbl[k].pre > 0) sf();
      for (int i = 0; i < SEG; i++) pix(tbl[k].base + 24'(i));
      @(posedge pclk);
      #1 ena = 1'b0;
      @(negedge pclk) v1 = tx_valid;
      @(negedge pclk) v2 = tx_valid;
      @(negedge pclk) v3 = tx_valid;
      check($sformatf("row%0d_latency", k), {v1, v2, v3}, 3'b001);
      wait_pkts(1, $sformatf("row%0d", k));
      add_pkt(tbl[k].exp_frame, tbl[k].base);
      cmp_stream($sformatf("row%0d", k));
      if (!tbl[k].bp && got_c.size() > 0)
        check($sformatf("row%0d_contig", k), 64'(got_c[got_c.size() - 1] - got_c[0]), 64'(PLEN - 1));
      check($sformatf("row%0d_drop", k), drop_count, 64'(tbl[k].exp_drop));
      check($sformatf("row%0d_frame", k), frame_no, tbl[k].exp_frame);
    end

    do_reset();
    sf();
    for (int i = 0; i < 3 * SEG; i++) pix(24'(i));
    @(posedge pclk);
    #1 ena = 1'b0;
    repeat (3) @(negedge pclk);
    check("drop_count", drop_count, 64'd1);
    check("drop_stalled_valid", tx_valid, 64'd1);
    @(posedge pclk);
    #1 tx_ready = 1'b1;
    wait_pkts(2, "drop");
    add_pkt(8'h01, 24'd0);
    add_pkt(8'h01, 24'd160);
    cmp_stream("drop");
    if (got_c.size() > 0) check("drop_b2b", 64'(got_c[got_c.size() - 1] - got_c[0]), 64'(2 * PLEN - 1));

    do_reset();
    tx_ready = 1'b1;
    sf();
    for (int i = 0; i < SEG; i++) pix(24'(i));
    @(posedge pclk);
    #1 ena = 1'b0;
    repeat (50) @(negedge pclk);
    check("rst_mid_active", tx_valid, 64'd1);
    #2 rstb = 1'b0;
    #1 check("rst_mid_clear", {tx_valid, tx_last, tx_data, frame_no, drop_count}, 64'd0);
    repeat (2) @(posedge pclk);
    #1 rstb = 1'b1;
    got_d.delete();
    repeat (700) @(negedge pclk);
    check("rst_no_resume", 64'(got_d.size()), 64'd0);
    check("rst_idle_valid", tx_valid, 64'd0);

    do_reset();
    repeat (255) sf();
    check("frame_ff", frame_no, 64'hFF);
    sf();
    check("frame_wrap", frame_no, 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
